// File: rtl/struct_s.sv
// Shared packet-processing types: protocol codes, per-packet metadata, header/tail sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package struct_s;

  typedef enum logic [1:0] {
    PROT_OTHER = 2'd0,
    PROT_TCP   = 2'd1,
    PROT_UDP   = 2'd2
  } prot_e;

  typedef struct packed {
    prot_e       prot;
    logic [55:0] last_7_bytes;  // most recent flow byte in [7:0]
  } metadata_t;

  typedef enum logic {
    IDLE = 1'b0,  // waiting for a sop flit
    BODY = 1'b1   // inside a packet
  } tail_state_e;

  localparam int TCP_HDR_LEN = 54;
  localparam int TAIL_LEN    = 7;
  localparam int FLIT_BYTES  = 64;

endpackage

// File: rtl/tcp_tail_capture_if.sv
// Bundle of the packet, metadata and tail handshakes around tcp_tail_capture.
// Latency: none (wires only).
// Backpressure: valid/ready on each channel; slave = capture block, master = its environment.
interface tcp_tail_capture_if;
  import struct_s::*;

  logic            in_pkt_sop;
  logic            in_pkt_eop;
  logic            in_pkt_valid;
  logic [511:0]    in_pkt_data;   // byte 0 of the flit at [511:504]
  logic [5:0]      in_pkt_empty;  // invalid low-end bytes on the eop flit
  logic            in_pkt_ready;
  metadata_t       in_meta_data;
  logic            in_meta_valid;
  logic            in_meta_ready;
  metadata_t       tail_meta;
  logic            tail_valid;
  logic            tail_ready;

  modport master (
    output in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty,
    output in_meta_data, in_meta_valid, tail_ready,
    input  in_pkt_ready, in_meta_ready, tail_meta, tail_valid
  );

  modport slave (
    input  in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty,
    input  in_meta_data, in_meta_valid, tail_ready,
    output in_pkt_ready, in_meta_ready, tail_meta, tail_valid
  );

endinterface

// File: rtl/tcp_tail_capture_merge.sv
// tail_merge: folds the payload bytes [lo,hi) of one flit into the 7-byte tail window.
// Latency: combinational.
// Backpressure: none; ports: w_in/flit_dat/lo/hi in, w_out (new window) and pay_cnt out.
module tail_merge
  import struct_s::*;
(
  input  logic [55:0]  w_in,      // current window, newest byte in [7:0]
  input  logic [511:0] flit_dat,  // flit, byte 0 at [511:504]
  input  logic [6:0]   lo,        // first payload byte index in this flit
  input  logic [6:0]   hi,        // one past last valid byte index (1..64)
  output logic [55:0]  w_out,
  output logic [6:0]   pay_cnt    // payload bytes contributed by this flit
);

  // Output byte k (k=0 newest) comes from flit byte hi-1-k while that is
  // still payload; past the payload it comes from the old window, shifted by
  // the payload count. This covers n=0, 0<n<7 and n>=7 in one expression.
  always_comb begin
    pay_cnt = (hi > lo) ? (hi - lo) : 7'd0;
    w_out   = '0;
    for (int k = 0; k < TAIL_LEN; k++) begin
      if (7'(k) < pay_cnt) begin
        w_out[8*k +: 8] = flit_dat[9'd504 - {6'(hi - 7'd1 - 7'(k)), 3'b000} +: 8];
      end else begin
        w_out[8*k +: 8] = w_in[{3'(k) - pay_cnt[2:0], 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/tcp_tail_capture.sv
// Tracks the last 7 payload bytes of each TCP packet and emits them as updated metadata.
// Latency: tail_valid one cycle after the accepted eop flit; one flit/cycle when tail_ready is high.
// Backpressure: a held, un-taken tail stalls in_pkt_ready; ports: clk, rst, bus (slave), err_cnt.
module tcp_tail_capture
  import struct_s::*;
(
  input  logic                clk,
  input  logic                rst,
  tcp_tail_capture_if.slave   bus,
  output logic [31:0]         err_cnt  // packets abandoned by a sop arriving mid-packet
);

  tail_state_e state_q, state_d;
  logic [55:0] w_q, w_d;
  logic        seen_q, seen_d;
  metadata_t   meta_q, meta_d;
  metadata_t   tail_meta_q, tail_meta_d;
  logic        tail_valid_q, tail_valid_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  logic        pkt_ready;
  logic        flit_use;
  logic        sop;
  logic        eop;
  metadata_t   cur_meta;
  logic [55:0] w_base;
  logic        seen_base;
  logic [6:0]  lo;
  logic [6:0]  hi;
  logic [55:0] w_new;
  logic [6:0]  pay_cnt;
  logic        seen_new;

  // A pending tail that is not being taken blocks input; in IDLE a flit
  // also needs metadata on offer, since only a sop can start a packet.
  assign pkt_ready = !rst && !(tail_valid_q && !bus.tail_ready) &&
                     ((state_q == BODY) || bus.in_meta_valid);

  assign bus.in_pkt_ready  = pkt_ready;
  assign bus.in_meta_ready = bus.in_pkt_valid & bus.in_pkt_sop & pkt_ready;
  assign bus.tail_meta     = tail_meta_q;
  assign bus.tail_valid    = tail_valid_q;
  assign err_cnt           = err_cnt_q;

  assign sop = bus.in_pkt_sop;
  assign eop = bus.in_pkt_eop;

  // Non-sop flits seen in IDLE are accepted but have no packet to belong to.
  assign flit_use = bus.in_pkt_valid && pkt_ready && (sop || (state_q == BODY));

  // A sop starts from fresh metadata and an empty payload history.
  assign cur_meta  = sop ? bus.in_meta_data : meta_q;
  assign w_base    = sop ? cur_meta.last_7_bytes : w_q;
  assign seen_base = sop ? 1'b0 : seen_q;

  // The header lives entirely in the first flit.
  assign lo = sop ? 7'(TCP_HDR_LEN) : 7'd0;
  assign hi = eop ? (7'(FLIT_BYTES) - {1'b0, bus.in_pkt_empty}) : 7'(FLIT_BYTES);

  tail_merge u_tail_merge (
    .w_in     (w_base),
    .flit_dat (bus.in_pkt_data),
    .lo       (lo),
    .hi       (hi),
    .w_out    (w_new),
    .pay_cnt  (pay_cnt)
  );

  assign seen_new = seen_base || (pay_cnt != 7'd0);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    seen_d       = seen_q;
    meta_d       = meta_q;
    tail_meta_d  = tail_meta_q;
    tail_valid_d = tail_valid_q;
    err_cnt_d    = err_cnt_q;

    if (tail_valid_q && bus.tail_ready) begin
      tail_valid_d = 1'b0;
    end

    if (flit_use) begin
      w_d    = w_new;
      seen_d = seen_new;
      if (sop) begin
        meta_d = bus.in_meta_data;
        if ((state_q == BODY) && (err_cnt_q != 32'hFFFF_FFFF)) begin
          err_cnt_d = err_cnt_q + 32'd1;
        end
      end

      if (eop) begin
        state_d = IDLE;
        if ((cur_meta.prot == PROT_TCP) && seen_new) begin
          tail_valid_d             = 1'b1;
          tail_meta_d              = cur_meta;
          tail_meta_d.last_7_bytes = w_new;
        end
      end else if (sop) begin
        state_d = BODY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      seen_q       <= 1'b0;
      meta_q       <= '0;
      tail_meta_q  <= '0;
      tail_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      seen_q       <= seen_d;
      meta_q       <= meta_d;
      tail_meta_q  <= tail_meta_d;
      tail_valid_q <= tail_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_tcp_tail_capture.sv
// Directed bench for tcp_tail_capture with a tail scoreboard fed at stimulus time.
// Latency: expects tail_valid one cycle after each accepted TCP eop with payload.
// Backpressure: tail_ready is toggled to exercise the input stall path.
module tb_tcp_tail_capture;
  import struct_s::*;

  typedef logic [7:0] byte_q_t [$];

  logic        clk;
  logic        rst;
  logic [31:0] err_cnt;

  tcp_tail_capture_if bus ();

  tcp_tail_capture dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  byte_q_t   pkt;
  metadata_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: append the payload (bytes from offset 54) to the prior tail and keep the last 7.
  function automatic logic [55:0] model_tail(input logic [55:0] prior, input byte_q_t b);
    byte_q_t     s;
    logic [55:0] r;
    for (int i = 0; i < 7; i++) s.push_back(prior[55-8*i -: 8]);
    for (int i = TCP_HDR_LEN; i < b.size(); i++) s.push_back(b[i]);
    r = '0;
    for (int k = 0; k < 7; k++) r[8*k +: 8] = s[s.size()-1-k];
    return r;
  endfunction

  task automatic fill_pkt(input int len, input logic [7:0] seed);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(seed + 8'(i * 5));
  endtask

  function automatic logic [511:0] flit_dat(input int f);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < 64; j++) begin
      if (f * 64 + j < pkt.size()) d[511-8*j -: 8] = pkt[f*64+j];
    end
    return d;
  endfunction

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send_flit(input logic sop, input logic eop, input logic [511:0] dat,
                           input logic [5:0] empty, input metadata_t meta, output int stalls);
    bit done;
    stalls = 0;
    done   = 0;
    bus.in_pkt_sop    = sop;
    bus.in_pkt_eop    = eop;
    bus.in_pkt_data   = dat;
    bus.in_pkt_empty  = empty;
    bus.in_pkt_valid  = 1'b1;
    bus.in_meta_data  = meta;
    bus.in_meta_valid = 1'b1;
    while (!done) begin
      #1;
      if (bus.in_pkt_ready) begin
        check("meta_ready", 64'(bus.in_meta_ready), 64'(sop));
        done = 1;
      end else if (stalls >= 200) begin
        checks++;
        errors++;
        $error("FAIL accept_timeout observed=stalled expected=accepted");
        done = 1;
      end else begin
        @(negedge clk);
        stalls++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_pkt_valid  = 1'b0;
    bus.in_pkt_sop    = 1'b0;
    bus.in_pkt_eop    = 1'b0;
    bus.in_meta_valid = 1'b0;
  endtask

  task automatic send_pkt(input prot_e prot, input logic [55:0] prior, input bit chk_lat,
                          output int stalls);
    metadata_t m;
    metadata_t e;
    int        len;
    int        nf;
    int        s;
    bit        want;
    len            = pkt.size();
    nf             = (len + 63) / 64;
    m.prot         = prot;
    m.last_7_bytes = prior;
    want           = (prot == PROT_TCP) && (len > TCP_HDR_LEN);
    if (want) begin
      e.prot         = prot;
      e.last_7_bytes = model_tail(prior, pkt);
      exp_q.push_back(e);
    end
    stalls = 0;
    for (int f = 0; f < nf; f++) begin
      send_flit(f == 0, f == nf - 1, flit_dat(f),
                (f == nf - 1) ? 6'(nf * 64 - len) : 6'd0, m, s);
      stalls += s;
    end
    if (chk_lat) check("tail_latency", 64'(bus.tail_valid), 64'(want));
  endtask

  // Scoreboard consumer plus hold-stability watch, sampled 1 time unit before each posedge.
  initial begin : monitor
    bit        prev_stall;
    metadata_t prev_meta;
    metadata_t e;
    prev_stall = 0;
    prev_meta  = '0;
    forever begin
      @(negedge clk);
      #4;
      if (prev_stall && !rst)
        check("hold_stable", 64'({bus.tail_valid, bus.tail_meta}), 64'({1'b1, prev_meta}));
      if (!rst && bus.tail_valid && bus.tail_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_tail observed=%0h expected=none", bus.tail_meta);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tail_meta", 64'(bus.tail_meta), 64'(e));
        end
      end
      prev_stall = !rst && bus.tail_valid && !bus.tail_ready;
      prev_meta  = bus.tail_meta;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int        st;
    metadata_t m;
    rst               = 1'b1;
    bus.in_pkt_sop    = 1'b1;
    bus.in_pkt_eop    = 1'b0;
    bus.in_pkt_valid  = 1'b1;
    bus.in_pkt_data   = '0;
    bus.in_pkt_empty  = '0;
    bus.in_meta_data  = '0;
    bus.in_meta_valid = 1'b1;
    bus.tail_ready    = 1'b1;

    // Reset values, and no ready while reset is held even with traffic offered.
    repeat (3) @(negedge clk);
    #1;
    check("rst_pkt_ready", 64'(bus.in_pkt_ready), 64'(0));
    check("rst_meta_ready", 64'(bus.in_meta_ready), 64'(0));
    check("rst_tail_valid", 64'(bus.tail_valid), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_tail_meta", 64'(bus.tail_meta), 64'(0));
    @(negedge clk);
    bus.in_pkt_valid  = 1'b0;
    bus.in_pkt_sop    = 1'b0;
    bus.in_meta_valid = 1'b0;
    rst               = 1'b0;
    @(negedge clk);

    // Single full flit: tail is packet bytes 57..63.
    fill_pkt(64, 8'h10);
    send_pkt(PROT_TCP, 56'h0, 1, st);
    // Three payload bytes AA BB CC appended to the prior tail.
    fill_pkt(57, 8'h20);
    pkt[54] = 8'hAA; pkt[55] = 8'hBB; pkt[56] = 8'hCC;
    send_pkt(PROT_TCP, 56'h11223344556677, 1, st);
    // Two flits, 4 valid bytes on the eop flit.
    fill_pkt(68, 8'h30);
    send_pkt(PROT_TCP, 56'hA1A2A3A4A5A6A7, 1, st);
    // Six payload bytes in one flit; three flits ending with 2 bytes.
    fill_pkt(60, 8'h41);
    send_pkt(PROT_TCP, 56'hF0E0D0C0B0A090, 1, st);
    fill_pkt(130, 8'h07);
    send_pkt(PROT_TCP, 56'h0123456789ABCD, 1, st);

    // UDP and header-only TCP: consumed with no tail and no stall.
    fill_pkt(100, 8'h55);
    send_pkt(PROT_UDP, 56'h0, 1, st);
    check("udp_stalls", 64'(st), 64'(0));
    fill_pkt(54, 8'h66);
    send_pkt(PROT_TCP, 56'h77, 1, st);
    check("zero_pay_stalls", 64'(st), 64'(0));

    // Pending tail stalls the next sop until tail_ready rises 5 cycles later.
    bus.tail_ready = 1'b0;
    fill_pkt(64, 8'h50);
    send_pkt(PROT_TCP, 56'h0, 1, st);
    fill_pkt(64, 8'h60);
    fork
      send_pkt(PROT_TCP, 56'h99887766554433, 0, st);
      begin
        repeat (5) @(negedge clk);
        bus.tail_ready = 1'b1;
      end
    join
    check("stall_cycles", 64'(st), 64'(5));
    check("stall_tail_valid", 64'(bus.tail_valid), 64'(1));

    // Abandoned packet: sop, body, then a new sop.
    m.prot         = PROT_TCP;
    m.last_7_bytes = 56'h0;
    fill_pkt(200, 8'h70);
    send_flit(1'b1, 1'b0, flit_dat(0), 6'd0, m, st);
    send_flit(1'b0, 1'b0, flit_dat(1), 6'd0, m, st);
    fill_pkt(64, 8'h80);
    send_pkt(PROT_TCP, 56'h01020304050607, 1, st);
    check("err_cnt_one", 64'(err_cnt), 64'(1));

    // Stray non-sop eop flit in IDLE is dropped.
    send_flit(1'b0, 1'b1, flit_dat(0), 6'd0, m, st);
    check("stray_no_tail", 64'(bus.tail_valid), 64'(0));
    check("stray_err_cnt", 64'(err_cnt), 64'(1));

    // Reset mid-packet: the closing flit afterwards must not produce a tail.
    fill_pkt(100, 8'h90);
    send_flit(1'b1, 1'b0, flit_dat(0), 6'd0, m, st);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_flit(1'b0, 1'b1, flit_dat(1), 6'd28, m, st);
    check("rst_mid_no_tail", 64'(bus.tail_valid), 64'(0));
    check("rst_mid_err_cnt", 64'(err_cnt), 64'(0));

    // Reset with a tail pending discards it.
    bus.tail_ready = 1'b0;
    fill_pkt(64, 8'hA0);
    send_flit(1'b1, 1'b1, flit_dat(0), 6'd0, m, st);
    check("pending_tail", 64'(bus.tail_valid), 64'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.tail_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pend_valid", 64'(bus.tail_valid), 64'(0));
    check("rst_pend_meta", 64'(bus.tail_meta), 64'(0));

    // Recovery after reset.
    fill_pkt(90, 8'hB3);
    send_pkt(PROT_TCP, 56'hDEADBEEFCAFE01, 1, st);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcp_tail_capture.md
TCP_TAIL_CAPTURE -- requirements
Module: tcp_tail_capture

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on posedge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_pkt_sop/in_pkt_eop/in_pkt_valid  in  1 each  packet flit qualifiers.
REQ-004 SHALL have ports: in_pkt_data  in  512  packet byte 0 at [511:504]; in_pkt_empty  in  6  invalid low-end bytes on eop flit; in_pkt_ready  out  1.
REQ-005 SHALL have ports: in_meta_data  in  metadata_t  per-packet metadata (prot, last_7_bytes); in_meta_valid  in  1; in_meta_ready  out  1.
REQ-006 SHALL have ports: tail_meta  out  metadata_t  copy of packet metadata with last_7_bytes replaced by the new tail; tail_valid  out  1; tail_ready  in  1.
REQ-007 SHALL have ports: err_cnt  out  32  count of packets abandoned by sop-without-eop.

Function
REQ-008 SHALL, per TCP packet, compute the new flow tail: the last 7 bytes of the concatenation of in_meta_data.last_7_bytes and the packet payload, most recent byte in bits [7:0].
REQ-009 SHALL treat packet bytes 0..TCP_HDR_LEN-1 (54) as header; payload is every valid byte at offset >=54, so flit 0 carries at most 10 payload bytes.
REQ-010 SHALL treat valid bytes per flit as 64 on non-eop flits and 64-in_pkt_empty on eop flits.
REQ-011 SHALL keep a 56-bit window W, loaded from in_meta_data.last_7_bytes on the accepted sop flit, then updated on every accepted flit: n>=7 payload bytes -> W = last 7 payload bytes; 0<n<7 -> W = (W<<8n)|payload bytes; n=0 -> unchanged.
REQ-012 SHALL keep a payload-seen flag, cleared at sop and set on any flit with n>0.
REQ-013 SHALL, on the accepted eop flit of a PROT_TCP packet with payload seen, load tail_meta and assert tail_valid on the next cycle.
REQ-014 SHALL consume PROT_UDP packets and zero-payload TCP packets without asserting tail_valid.
REQ-015 SHALL hold tail_valid and tail_meta stable until tail_valid&tail_ready; then clear tail_valid the following cycle unless a new tail loads in that same cycle.
REQ-016 SHALL have states IDLE (await sop) and BODY (mid-packet); IDLE->BODY on accepted sop without eop; BODY->IDLE on accepted eop; sop+eop flit stays IDLE.
REQ-017 SHALL drive in_pkt_ready = !(tail_valid & !tail_ready) & (state==BODY | in_meta_valid).
REQ-018 SHALL drive in_meta_ready = in_pkt_valid & in_pkt_sop & in_pkt_ready; metadata is consumed only with the sop flit.
REQ-019 SHALL, on an accepted sop in BODY, drop the open packet with no tail, increment err_cnt (saturating at 2^32-1), and start the new packet.
REQ-020 SHALL ignore accepted non-sop flits in IDLE; these flits are discarded.
REQ-021 SHALL accept one flit per cycle with no bubbles when tail_ready is held high; the eop-to-tail_valid latency is 1 cycle.

Reset
REQ-022 SHALL, on rst, set state=IDLE, tail_valid=0, err_cnt=0, W=0, payload-seen=0, and clear tail_meta to 0.
REQ-023 SHALL, on rst mid-packet or with a tail pending, discard both; no tail_valid is asserted after reset for pre-reset data.
REQ-024 SHALL drive in_pkt_ready and in_meta_ready low while rst is high.

Structure
REQ-025 SHALL take metadata_t, PROT_TCP and PROT_UDP from the shared struct_s package; TCP_HDR_LEN=54 and TAIL_LEN=7 SHALL be added to that package.
REQ-026 SHALL place the combinational window update (W, flit, byte range -> W') in one sub-module, tail_merge; the FSM, counters and hold register stay in tcp_tail_capture.

Verification
REQ-027 Single-flit TCP, empty=0, meta tail=0x00000000000000 -> tail_valid next cycle, last_7_bytes = packet bytes 57..63.
REQ-028 Single-flit TCP, empty=7 (3 payload bytes AA BB CC), meta tail=0x11223344556677 -> last_7_bytes=0x44556677AABBCC.
REQ-029 Two-flit TCP, eop flit empty=60 (4 valid bytes) -> tail = payload bytes 61..63 of flit 0 followed by the 4 bytes of flit 1.
REQ-030 UDP packet and TCP packet with empty=10 (zero payload) -> no tail_valid; in_pkt_ready stays high.
REQ-031 Back-to-back single-flit TCP packets with tail_ready=0 for 5 cycles -> second sop stalls (in_pkt_ready=0) until the handshake, then tail_valid follows 1 cycle after acceptance; no tail lost.
REQ-032 sop, body, then new sop before eop -> err_cnt 0->1, only the second packet's tail emitted; rst mid-packet -> no tail emitted.
